// File: rtl/toggle_dec_pkg.sv
// Shared types and parameter limits for the toggle decoder.
// FSM state encoding lives here so the top and the bench agree on it.
package toggle_dec_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam int SYNC_DEF = 2;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    localparam int FILT_DEF = 3;
    localparam int FILT_MIN = 1;
    localparam int FILT_MAX = 15;

    localparam int CNTW_DEF = 8;
    localparam int CNTW_MIN = 2;
    localparam int CNTW_MAX = 16;

    localparam int FCNT_W = 4;

endpackage

// File: rtl/toggle_decoder_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Synchronous active-low reset clears every stage.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// Debounced toggle decoder: synchronizes a toggling level, filters it,
// and emits a strobe plus a saturating count per accepted change.
module toggle_decoder
    import toggle_dec_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int FILT_CYCLES = FILT_DEF,
    parameter int CNT_W       = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             t_in,
    input  logic             clr_cnt,
    output logic             lvl_q,
    output logic             tgl_pulse,
    output logic [CNT_W-1:0] tgl_cnt,
    output logic             cnt_sat
);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("toggle_decoder: SYNC_STAGES out of range 2..4");
    end
    if (FILT_CYCLES < FILT_MIN || FILT_CYCLES > FILT_MAX) begin : g_bad_filt
        $error("toggle_decoder: FILT_CYCLES out of range 1..15");
    end
    if (CNT_W < CNTW_MIN || CNT_W > CNTW_MAX) begin : g_bad_cntw
        $error("toggle_decoder: CNT_W out of range 2..16");
    end

    localparam bit              NO_FILT   = (FILT_CYCLES == 1);
    localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_CYCLES - 1);

    logic s;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (t_in),
        .q   (s)
    );

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                pulse_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q;
    logic                diff;
    logic                accept;

    assign diff = s ^ lvl_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (diff && !NO_FILT) state_d = CHECK;
            end
            CHECK: begin
                if (!diff || fcnt_q == FILT_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe in the previous cycle blocks unfiltered re-acceptance,
    // so pulses are always separated by at least one idle sample.
    always_comb begin
        accept = 1'b0;
        fcnt_d = fcnt_q;
        unique case (state_q)
            IDLE: begin
                fcnt_d = (diff && !NO_FILT) ? FCNT_W'(1) : '0;
                accept = diff && NO_FILT && !pulse_q;
            end
            CHECK: begin
                if (!diff) begin
                    fcnt_d = '0;
                end else if (fcnt_q == FILT_LAST) begin
                    accept = 1'b1;
                    fcnt_d = '0;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end
            default: begin
                accept = 1'b0;
                fcnt_d = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = accept ? CNT_W'(1) : '0;
        end else if (accept && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fcnt_q  <= '0;
            lvl_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            lvl_q   <= lvl_q ^ accept;
            pulse_q <= accept;
            cnt_q   <= cnt_d;
            sat_q   <= &cnt_d;
        end
    end

    assign tgl_pulse = pulse_q;
    assign tgl_cnt   = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder: default instance plus a CNT_W=2
// instance for saturation, checked with immediate assertions.
module tb_toggle_decoder;

    logic       clk;
    logic       rstn;
    logic       t_in, clr_cnt;
    logic       lvl_q, tgl_pulse, cnt_sat;
    logic [7:0] tgl_cnt;
    logic       t2, clr2;
    logic       lvl2, pulse2, sat2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;
    int pcount = 0;
    int consec = 0;
    logic prev_pulse = 1'b0;

    toggle_decoder dut (
        .clk      (clk),
        .rstn     (rstn),
        .t_in     (t_in),
        .clr_cnt  (clr_cnt),
        .lvl_q    (lvl_q),
        .tgl_pulse(tgl_pulse),
        .tgl_cnt  (tgl_cnt),
        .cnt_sat  (cnt_sat)
    );

    toggle_decoder #(.CNT_W(2)) dut2 (
        .clk      (clk),
        .rstn     (rstn),
        .t_in     (t2),
        .clr_cnt  (clr2),
        .lvl_q    (lvl2),
        .tgl_pulse(pulse2),
        .tgl_cnt  (cnt2),
        .cnt_sat  (sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tgl_pulse && prev_pulse) consec++;
            if (tgl_pulse) pcount++;
            prev_pulse = tgl_pulse;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int pc0;
        logic [1:0] exp_c [5];
        logic       exp_s [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rstn = 1'b0; t_in = 1'b0; clr_cnt = 1'b0;
        t2 = 1'b0; clr2 = 1'b0;
        tick(3);
        chk("rst_lvl", 32'(lvl_q), 0);
        chk("rst_pulse", 32'(tgl_pulse), 0);
        chk("rst_cnt", 32'(tgl_cnt), 0);
        chk("rst_sat", 32'(cnt_sat), 0);
        rstn = 1'b1;
        tick(10);

        // glitch: two cycles high then low
        pc0 = pcount;
        t_in = 1'b1;
        tick(2);
        t_in = 1'b0;
        tick(10);
        chk("glitch_pulses", 32'(pcount - pc0), 0);
        chk("glitch_lvl", 32'(lvl_q), 0);
        chk("glitch_cnt", 32'(tgl_cnt), 0);

        // clean 0->1, accepted at edge 4 after the change
        pc0 = pcount;
        t_in = 1'b1;
        tick(4);
        chk("lat_pre_pulse", 32'(pcount - pc0), 0);
        chk("lat_pre_lvl", 32'(lvl_q), 0);
        tick(1);
        chk("lat_pulse", 32'(tgl_pulse), 1);
        chk("lat_lvl", 32'(lvl_q), 1);
        chk("lat_cnt", 32'(tgl_cnt), 1);
        tick(1);
        chk("lat_pulse_end", 32'(tgl_pulse), 0);

        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        chk("clr_alone", 32'(tgl_cnt), 0);

        for (int k = 0; k < 20; k++) begin
            pc0 = pcount;
            t_in = ~t_in;
            tick(8);
            chk($sformatf("tog%0d_pulses", k), 32'(pcount - pc0), 1);
        end
        chk("tog_cnt", 32'(tgl_cnt), 20);
        chk("tog_lvl", 32'(lvl_q), 32'(t_in));

        for (int k = 0; k < 5; k++) begin
            t2 = ~t2;
            tick(8);
            chk($sformatf("sat_cnt%0d", k), 32'(cnt2), 32'(exp_c[k]));
            chk($sformatf("sat_flag%0d", k), 32'(sat2), 32'(exp_s[k]));
        end

        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        for (int k = 0; k < 7; k++) begin
            t_in = ~t_in;
            tick(8);
        end
        chk("pre_clr_cnt", 32'(tgl_cnt), 7);
        t_in = ~t_in;
        tick(4);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        chk("clr_acc_pulse", 32'(tgl_pulse), 1);
        chk("clr_acc_cnt", 32'(tgl_cnt), 1);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        chk("clr_only_cnt", 32'(tgl_cnt), 0);

        // reset while the filter is part way through a change
        t_in = 1'b0;
        tick(8);
        pc0 = pcount;
        t_in = 1'b1;
        tick(3);
        rstn = 1'b0;
        tick(1);
        chk("midrst_pulses", 32'(pcount - pc0), 0);
        chk("midrst_lvl", 32'(lvl_q), 0);
        chk("midrst_cnt", 32'(tgl_cnt), 0);
        chk("midrst_sat", 32'(cnt_sat), 0);
        rstn = 1'b1;
        tick(4);
        chk("rel_pre_pulse", 32'(pcount - pc0), 0);
        tick(1);
        chk("rel_pulse", 32'(tgl_pulse), 1);
        chk("rel_lvl", 32'(lvl_q), 1);
        chk("rel_cnt", 32'(tgl_cnt), 1);
        tick(2);
        chk("no_consec_pulse", 32'(consec), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on t_in; legal range 2..4.
REQ-002 SHALL have parameter FILT_CYCLES, default 3: consecutive samples required to accept a level change; legal range 1..15, where 1 means no filtering.
REQ-003 SHALL have parameter CNT_W, default 8: width of the toggle counter; legal range 2..16.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port t_in, input, 1 bit: asynchronous level from a toggling source, e.g. the q output of a T flip-flop.
REQ-007 SHALL have port clr_cnt, input, 1 bit: synchronous clear request for tgl_cnt.
REQ-008 SHALL have port lvl_q, output, 1 bit: filtered, accepted level of t_in.
REQ-009 SHALL have port tgl_pulse, output, 1 bit: one-cycle strobe per accepted toggle.
REQ-010 SHALL have port tgl_cnt, output, CNT_W bits: count of accepted toggles.
REQ-011 SHALL have port cnt_sat, output, 1 bit: high while tgl_cnt equals all-ones.

Function
REQ-012 SHALL pass t_in through a SYNC_STAGES-deep flop chain; s denotes the last-stage output.
REQ-013 SHALL implement a two-state FSM with states IDLE and CHECK.
- IDLE: holds while s equals lvl_q.
- IDLE: moves to CHECK, with filter count = 1, on an edge where s differs from lvl_q.
REQ-014 In CHECK, at each edge:
- if s equals lvl_q (bounce), SHALL return to IDLE with no pulse and no count change;
- otherwise SHALL increment the filter count.
REQ-015 SHALL accept a change on the edge where s has differed from lvl_q for FILT_CYCLES consecutive samples. On that edge:
- lvl_q is inverted;
- tgl_pulse is high for exactly the following cycle;
- the FSM returns to IDLE.
REQ-016 When FILT_CYCLES = 1, SHALL accept the change directly from IDLE on the first differing sample, without visiting CHECK.
REQ-017 Latency: with t_in changed before edge 0 and held stable, lvl_q and tgl_pulse SHALL update at edge SYNC_STAGES+FILT_CYCLES-1 (edge 4 with defaults).
REQ-018 tgl_pulse SHALL never be high on two consecutive cycles; this is guaranteed because a new acceptance needs at least one IDLE sample.
REQ-019 tgl_cnt SHALL increment by 1 on every accepted toggle and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-020 clr_cnt high at an edge SHALL set tgl_cnt to 0. If a toggle is accepted on the same edge, tgl_cnt SHALL become 1.
REQ-021 cnt_sat SHALL be a registered flag consistent with tgl_cnt in the same cycle.
REQ-022 All outputs SHALL be registered; no combinational path from t_in or clr_cnt to any output.

Reset
REQ-023 rstn low at an edge SHALL set all of the following, overriding clr_cnt and any pending acceptance:
- synchronizer flops 0;
- lvl_q 0;
- FSM state IDLE;
- filter count 0;
- tgl_pulse 0;
- tgl_cnt 0;
- cnt_sat 0.
REQ-024 If t_in is 1 when rstn deasserts, SHALL treat it as a toggle and accept it per REQ-015/REQ-017, counting it.
REQ-025 Reset asserted while in CHECK SHALL discard the partial filter count, with no pulse.

Structure
REQ-026 SHALL place the FSM state enum and the parameter defaults/limits in package toggle_dec_pkg.
REQ-027 SHALL implement the flop chain as sub-module bit_sync (parameter STAGES, ports clk, rstn, d, q).
REQ-028 SHALL flag illegal parameter values with an elaboration-time check.

Verification
REQ-029 Bench SHALL cover these directed scenarios (defaults unless stated):
- Reset release with t_in=0, then t_in 0->1 before edge 10 and held: tgl_pulse high only in the cycle after edge 14; lvl_q=1; tgl_cnt=1.
- Glitch: t_in high for exactly 2 cycles then low: no pulse, lvl_q stays 0, tgl_cnt unchanged.
- 20 clean toggles spaced 8 cycles apart: 20 single-cycle pulses, tgl_cnt=20, lvl_q matches t_in.
- CNT_W=2, 5 accepted toggles: tgl_cnt sequence 1,2,3,3,3; cnt_sat high from the third toggle onward.
- clr_cnt asserted on the acceptance edge of a toggle with tgl_cnt=7: tgl_cnt=1 next cycle; clr_cnt alone gives 0.
- rstn pulled low mid-CHECK: no pulse, all outputs 0 next cycle. After release with t_in=1, a toggle is accepted at edge 4 after release.
